polyphase_decimator: RTL

// - Decimating polyphase FIR. The receive-side counterpart of the interpolating polyphase filter.
// - Accepts RATE_CHANGE input samples per output sample and emits one filtered sample per group.
// - Uses one time-multiplexed MAC over all taps. Each output is a direct-form FIR result

---
 rtl/polyphase_decimator_pkg.sv | 7 +
 rtl/polyphase_decimator_if.sv | 9 +
 rtl/polyphase_decimator_coeff_ram.sv | 18 +
 rtl/polyphase_decimator.sv | 123 ++++++++++++
 4 files changed

// File: rtl/polyphase_decimator_pkg.sv
// polyphase_decimator_pkg: shared FSM states and accumulator sizing for the polyphase filters
package polyphase_decimator_pkg;
  typedef enum logic [1:0] {ACCEPT, FLUSH, MAC, OUTPUT} state_t;
  function automatic int acc_width(int din, int coef, int taps);
    return din + coef + $clog2(taps);
  endfunction
endpackage

// File: rtl/polyphase_decimator_if.sv
// polyphase_decimator_if: AXI-Stream-style sample channel
interface polyphase_decimator_if #(parameter int W = 16);
  logic signed [W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/polyphase_decimator_coeff_ram.sv
// polyphase_decimator_coeff_ram: coefficient store, one write port and one registered read port
module polyphase_decimator_coeff_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             we,
  input  logic        [$clog2(DEPTH)-1:0] waddr,
  input  logic signed [WIDTH-1:0]          wdata,
  input  logic        [$clog2(DEPTH)-1:0] raddr,
  output logic signed [WIDTH-1:0]          rdata
);
  logic signed [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/polyphase_decimator.sv
// polyphase_decimator: decimate-by-M FIR using one time-multiplexed MAC over all taps
module polyphase_decimator
  import polyphase_decimator_pkg::*;
#(
  parameter int NUMBER_TAPS       = 32,
  parameter int RATE_CHANGE       = 8,
  parameter int DATA_IN_WIDTH     = 16,
  parameter int DATA_OUT_WIDTH    = 16,
  parameter int COEFFICIENT_WIDTH = 16,
  parameter int OUTPUT_SHIFT      = 0
) (
  input  logic                                  clock,
  input  logic                                  reset,
  polyphase_decimator_if.slave                  data_in,
  polyphase_decimator_if.master                 data_out,
  input  logic                                  coeffs_wren,
  input  logic        [$clog2(NUMBER_TAPS)-1:0] coeffs_addr,
  input  logic signed [COEFFICIENT_WIDTH-1:0]   coeffs_wdata,
  output logic                                  busy
);
  localparam int AW  = acc_width(DATA_IN_WIDTH, COEFFICIENT_WIDTH, NUMBER_TAPS);
  localparam int TW  = $clog2(NUMBER_TAPS);
  localparam int PW  = $clog2(RATE_CHANGE);
  localparam int CW  = $clog2(NUMBER_TAPS + 2);
  localparam int PRW = DATA_IN_WIDTH + COEFFICIENT_WIDTH;
  localparam int DW  = DATA_OUT_WIDTH;
  state_t state_q, state_d;
  logic signed [DATA_IN_WIDTH-1:0] x_q [NUMBER_TAPS];
  logic signed [DATA_IN_WIDTH-1:0] x_d [NUMBER_TAPS];
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [PRW-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc_q, acc_d, sum, shifted;
  logic signed [COEFFICIENT_WIDTH-1:0] coeff_rd;
  logic signed [DW-1:0] tdata_q, tdata_d, sat;
  logic pend_q, pend_d, tready_q, tready_d, tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic in_hs, out_hs, ovf, last_phase;
  polyphase_decimator_coeff_ram #(.DEPTH(NUMBER_TAPS), .WIDTH(COEFFICIENT_WIDTH)) u_ram (
    .clock(clock), .we(coeffs_wren), .waddr(coeffs_addr), .wdata(coeffs_wdata),
    .raddr(cnt_q[TW-1:0]), .rdata(coeff_rd)
  );
  assign in_hs      = data_in.tvalid & tready_q;
  assign out_hs     = tvalid_q & data_out.tready;
  assign last_phase = phase_q == PW'(RATE_CHANGE - 1);
  assign sum        = acc_q + AW'(prod_q);
  assign shifted    = sum >>> OUTPUT_SHIFT;
  assign ovf        = |shifted[AW-1:DW-1] && !(&shifted[AW-1:DW-1]);
  assign sat        = ovf ? {shifted[AW-1], {(DW-1){~shifted[AW-1]}}} : shifted[DW-1:0];
  assign data_in.tready  = tready_q;
  assign data_out.tvalid = tvalid_q;
  assign data_out.tdata  = tdata_q;
  assign data_out.tlast  = tlast_q;
  assign busy            = state_q != ACCEPT;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = '0;
    acc_d   = '0;
    pend_d  = pend_q;
    tdata_d = tdata_q;
    tlast_d = tlast_q;
    x_d     = x_q;
    // RAM read for tap j lands one cycle later, so the matching sample index lags the counter by one
    prod_d  = coeff_rd * x_q[TW'(cnt_q - 1'b1)];
    if (in_hs || state_q == FLUSH) begin
      x_d[0] = state_q == FLUSH ? '0 : data_in.tdata;
      for (int i = 1; i < NUMBER_TAPS; i++) x_d[i] = x_q[i-1];
      phase_d = phase_q + 1'b1;
    end
    if (state_q == ACCEPT && in_hs) begin
      pend_d  = pend_q | data_in.tlast;
      state_d = last_phase ? MAC : data_in.tlast ? FLUSH : ACCEPT;
    end
    if (state_q == FLUSH && last_phase) state_d = MAC;
    if (state_q == MAC) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = cnt_q >= CW'(2) ? sum : acc_q;
      if (cnt_q == CW'(NUMBER_TAPS + 1)) begin
        state_d = OUTPUT;
        tdata_d = sat;
        tlast_d = pend_q;
      end
    end
    if (state_q == OUTPUT && out_hs) begin
      state_d = ACCEPT;
      tlast_d = 1'b0;
      if (pend_q) begin
        x_d     = '{default: '0};
        phase_d = '0;
        pend_d  = 1'b0;
      end
    end
    tready_d = state_d == ACCEPT;
    tvalid_d = state_d == OUTPUT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ACCEPT;
      phase_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      pend_q   <= 1'b0;
      x_q      <= '{default: '0};
      tready_q <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      pend_q   <= pend_d;
      x_q      <= x_d;
      tready_q <= tready_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
    end
  end
endmodule
